dff_bank_arbiter: RTL and testbench

- Round-robin arbiter that shares a single WIDTH-bit D-flip-flop storage register between NUM_REQ requesters.
- Each requester presents data and raises a request.
- The arbiter selects one requester and loads its data into the shared register. It then completes a four-phase req/ack handshake with that requester.
- Sits between requester logic and the shared D-flip-flop bank; it is the sole writer of that register.

---
 rtl/dff_bank_arbiter_if.sv | 36 +++
 rtl/dff_bank_arbiter.sv | 158 +++++++++++++++
 tb/tb_dff_bank_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dff_bank_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: request/data in, ack and register view out.
interface dff_bank_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8
);
  logic [NUM_REQ-1:0]         req;
  logic [NUM_REQ*WIDTH-1:0]   d_in;
  logic [NUM_REQ-1:0]         ack;
  logic [WIDTH-1:0]           q;
  logic                       q_valid;
  logic [$clog2(NUM_REQ)-1:0] owner;
  logic                       busy;
  logic                       timeout_err;

  modport master (
    output req,
    output d_in,
    input  ack,
    input  q,
    input  q_valid,
    input  owner,
    input  busy,
    input  timeout_err
  );

  modport slave (
    input  req,
    input  d_in,
    output ack,
    output q,
    output q_valid,
    output owner,
    output busy,
    output timeout_err
  );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter owning a shared WIDTH-bit register, with a four-phase req/ack handshake.
// Optional forced release after TIMEOUT cycles in release: define DFF_ARB_TIMEOUT_EN.
module dff_bank_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  dff_bank_arbiter_if.slave bus
);
  localparam int unsigned IdxW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 16 || TIMEOUT == 0) begin : g_param_check
    $error("dff_bank_arbiter: NUM_REQ must be 2..16 and TIMEOUT nonzero");
  end

  typedef enum logic [1:0] {StIdle, StWrite, StRelease} state_e;

  state_e             r_state, w_state_d;
  logic [IdxW-1:0]    r_ptr, w_ptr_d;
  logic [IdxW-1:0]    r_gnt, w_gnt_d;
  logic [IdxW-1:0]    r_owner, w_owner_d;
  logic [WIDTH-1:0]   r_q, w_q_d;
  logic               r_q_valid, w_q_valid_d;
  logic [NUM_REQ-1:0] r_ack, w_ack_d;
  logic               w_release;

  logic               w_any;
  logic [IdxW-1:0]    w_winner;
  logic [IdxW:0]      w_sum;
  logic [IdxW-1:0]    w_gnt_next;
  logic [NUM_REQ-1:0] w_onehot;

  // First set request at or above ptr, wrapping modulo NUM_REQ.
  always_comb begin
    w_any    = 1'b0;
    w_winner = r_ptr;
    w_sum    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IdxW+1)'(k);
      if (w_sum >= (IdxW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (IdxW+1)'(NUM_REQ);
      end
      if (!w_any && bus.req[w_sum[IdxW-1:0]]) begin
        w_any    = 1'b1;
        w_winner = w_sum[IdxW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_next = (r_gnt == IdxW'(NUM_REQ - 1)) ? '0 : r_gnt + 1'b1;
    w_onehot   = '0;
    w_onehot[r_gnt] = 1'b1;
  end

`ifdef DFF_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT + 1);

  logic [CntW-1:0] r_cnt, w_cnt_d;
  logic            r_terr, w_terr_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_terr <= 1'b0;
    end else begin
      r_cnt  <= w_cnt_d;
      r_terr <= w_terr_d;
    end
  end

  assign bus.timeout_err = r_terr;
`else
  assign bus.timeout_err = 1'b0;
`endif

  always_comb begin
    w_state_d   = r_state;
    w_ptr_d     = r_ptr;
    w_gnt_d     = r_gnt;
    w_q_d       = r_q;
    w_q_valid_d = r_q_valid;
    w_owner_d   = r_owner;
    w_ack_d     = r_ack;
    w_release   = 1'b0;
`ifdef DFF_ARB_TIMEOUT_EN
    w_cnt_d     = r_cnt;
    w_terr_d    = 1'b0;
`endif
    unique case (r_state)
      StIdle: begin
        if (w_any) begin
          w_gnt_d   = w_winner;
          w_state_d = StWrite;
        end
      end
      StWrite: begin
        w_q_d       = bus.d_in[32'(r_gnt) * WIDTH +: WIDTH];
        w_q_valid_d = 1'b1;
        w_owner_d   = r_gnt;
        w_ack_d     = w_onehot;
        w_state_d   = StRelease;
`ifdef DFF_ARB_TIMEOUT_EN
        w_cnt_d     = '0;
`endif
      end
      StRelease: begin
        if (!bus.req[r_gnt]) begin
          w_release = 1'b1;
`ifdef DFF_ARB_TIMEOUT_EN
        end else if (r_cnt == CntW'(TIMEOUT - 1)) begin
          w_release = 1'b1;
          w_terr_d  = 1'b1;
        end else begin
          w_cnt_d = r_cnt + 1'b1;
`endif
        end
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase

    if (w_release) begin
      w_ack_d   = '0;
      w_ptr_d   = w_gnt_next;
      w_state_d = StIdle;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= StIdle;
      r_ptr     <= '0;
      r_gnt     <= '0;
      r_q       <= '0;
      r_q_valid <= 1'b0;
      r_owner   <= '0;
      r_ack     <= '0;
    end else begin
      r_state   <= w_state_d;
      r_ptr     <= w_ptr_d;
      r_gnt     <= w_gnt_d;
      r_q       <= w_q_d;
      r_q_valid <= w_q_valid_d;
      r_owner   <= w_owner_d;
      r_ack     <= w_ack_d;
    end
  end

  assign bus.ack     = r_ack;
  assign bus.q       = r_q;
  assign bus.q_valid = r_q_valid;
  assign bus.owner   = r_owner;
  assign bus.busy    = (r_state != StIdle);
endmodule

// File: tb/tb_dff_bank_arbiter.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a transaction-level model of the arbiter.
module tb_dff_bank_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int TO = 16;

  logic clk;
  logic reset;

  dff_bank_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();

  dff_bank_arbiter #(
    .NUM_REQ(N),
    .WIDTH  (W),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;

  // Model: m_gnt < 0 means no transaction; m_age counts edges since the grant.
  int           m_gnt;
  int           m_age;
  int           m_ptr;
  logic [1:0]   m_owner;
  logic [W-1:0] m_q;
  logic         m_qv;
  logic [N-1:0] m_ack;
  logic         m_terr;

  task automatic model_reset();
    m_gnt   = -1;
    m_age   = 0;
    m_ptr   = 0;
    m_owner = '0;
    m_q     = '0;
    m_qv    = 1'b0;
    m_ack   = '0;
    m_terr  = 1'b0;
  endtask

  task automatic model_finish_tx();
    m_ack = '0;
    m_ptr = (m_gnt + 1) % N;
    m_gnt = -1;
  endtask

  // Applies one rising edge to the model using the inputs currently on the bus.
  task automatic model_edge();
    if (!reset) begin
      model_reset();
      return;
    end
    m_terr = 1'b0;
    if (m_gnt < 0) begin
      for (int k = 0; k < N; k++) begin
        if (m_gnt < 0 && bus.req[(m_ptr + k) % N]) begin
          m_gnt = (m_ptr + k) % N;
          m_age = 0;
        end
      end
    end else if (m_age == 0) begin
      m_q     = bus.d_in[m_gnt*W +: W];
      m_qv    = 1'b1;
      m_owner = 2'(m_gnt);
      m_ack   = '0;
      m_ack[m_gnt] = 1'b1;
      m_age   = 1;
    end else if (!bus.req[m_gnt]) begin
      model_finish_tx();
    end else begin
`ifdef DFF_ARB_TIMEOUT_EN
      if (m_age == TO) begin
        model_finish_tx();
        m_terr = 1'b1;
      end else begin
        m_age++;
      end
`endif
    end
  endtask

  task automatic compare();
    logic exp_busy;
    exp_busy = (m_gnt >= 0);
    n_checks++;
    if (bus.q === m_q && bus.q_valid === m_qv && bus.owner === m_owner &&
        bus.ack === m_ack && bus.busy === exp_busy && bus.timeout_err === m_terr) begin
      n_pass++;
    end else begin
      $display("FAIL cycle %0d outputs: got q=%h qv=%b own=%0d ack=%b busy=%b terr=%b, want q=%h qv=%b own=%0d ack=%b busy=%b terr=%b",
               cycle, bus.q, bus.q_valid, bus.owner, bus.ack, bus.busy, bus.timeout_err,
               m_q, m_qv, m_owner, m_ack, exp_busy, m_terr);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cycle++;
    compare();
  endtask

  task automatic async_reset();
    reset = 1'b0;
    #1;
    model_reset();
    compare();
  endtask

  initial begin
    logic [N-1:0] exp_own [5];
    logic [W-1:0] dat     [4];

    reset    = 1'b0;
    bus.req  = '0;
    bus.d_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare();
    check_lit("reset_q", 32'(bus.q), 32'h0);
    check_lit("reset_busy", 32'(bus.busy), 32'h0);
    reset = 1'b1;

    // Single request
    bus.req = 4'b0001;
    bus.d_in[7:0] = 8'hA5;
    step();
    check_lit("single_busy", 32'(bus.busy), 32'h1);
    check_lit("single_ack0", 32'(bus.ack), 32'h0);
    step();
    check_lit("single_q", 32'(bus.q), 32'hA5);
    check_lit("single_qv", 32'(bus.q_valid), 32'h1);
    check_lit("single_owner", 32'(bus.owner), 32'h0);
    check_lit("single_ack", 32'(bus.ack), 32'h1);
    bus.req = '0;
    step();
    check_lit("single_rel_ack", 32'(bus.ack), 32'h0);
    check_lit("single_rel_busy", 32'(bus.busy), 32'h0);

    // Contention from ptr=0
    async_reset();
    step();
    reset = 1'b1;
    dat[0] = 8'h10; dat[1] = 8'h21; dat[2] = 8'h32; dat[3] = 8'h43;
    for (int i = 0; i < N; i++) bus.d_in[i*W +: W] = dat[i];
    exp_own[0] = 0; exp_own[1] = 1; exp_own[2] = 2; exp_own[3] = 3; exp_own[4] = 0;
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      step();
      step();
      check_lit($sformatf("rr_owner%0d", t), 32'(bus.owner), 32'(exp_own[t]));
      check_lit($sformatf("rr_q%0d", t), 32'(bus.q), 32'(dat[exp_own[t]]));
      bus.req[exp_own[t]] = 1'b0;
      step();
      check_lit($sformatf("rr_rel%0d", t), 32'(bus.ack), 32'h0);
      bus.req[exp_own[t]] = 1'b1;
    end
    bus.req = '0;
    step();

    // Wrap priority: serve 2, then 4'b0011 must pick 0 before 1
    bus.req = 4'b0100;
    step(); step();
    check_lit("wrap_owner2", 32'(bus.owner), 32'h2);
    bus.req = 4'b0011;
    step();
    step(); step();
    check_lit("wrap_owner0", 32'(bus.owner), 32'h0);
    bus.req = 4'b0010;
    step(); step(); step();
    check_lit("wrap_owner1", 32'(bus.owner), 32'h1);
    check_lit("wrap_q1", 32'(bus.q), 32'h21);
    bus.req = '0;
    step();

    // Reset mid-simulation with junk inputs, held for a few cycles
    async_reset();
    for (int i = 0; i < 3; i++) begin
      bus.req  = 4'($urandom);
      bus.d_in = $urandom;
      step();
      check_lit($sformatf("junk_q%0d", i), 32'(bus.q), 32'h0);
      check_lit($sformatf("junk_ack%0d", i), 32'(bus.ack), 32'h0);
      check_lit($sformatf("junk_qv%0d", i), 32'(bus.q_valid), 32'h0);
    end
    bus.req = '0;
    reset = 1'b1;
    step();

    // Reset during release
    bus.d_in = 32'h43322110;
    bus.req  = 4'b0100;
    step(); step(); step();
    check_lit("midrst_ack_before", 32'(bus.ack), 32'h4);
    async_reset();
    check_lit("midrst_ack", 32'(bus.ack), 32'h0);
    check_lit("midrst_busy", 32'(bus.busy), 32'h0);
    check_lit("midrst_q", 32'(bus.q), 32'h0);
    step();
    reset   = 1'b1;
    bus.req = 4'b0110;
    step(); step();
    check_lit("midrst_owner", 32'(bus.owner), 32'h1);
    bus.req = '0;
    step();

    // Hold req[1] indefinitely
    bus.req = 4'b0010;
    step(); step();
    check_lit("hold_ack", 32'(bus.ack), 32'h2);
`ifdef DFF_ARB_TIMEOUT_EN
    for (int i = 0; i < TO - 1; i++) begin
      step();
      check_lit($sformatf("to_hold%0d", i), 32'(bus.ack), 32'h2);
    end
    step();
    check_lit("to_ack", 32'(bus.ack), 32'h0);
    check_lit("to_err", 32'(bus.timeout_err), 32'h1);
    bus.req = 4'b0110;
    step();
    check_lit("to_err_pulse", 32'(bus.timeout_err), 32'h0);
    step();
    check_lit("to_next_owner", 32'(bus.owner), 32'h2);
`else
    for (int i = 0; i < TO + 4; i++) begin
      step();
      check_lit($sformatf("hold%0d", i), {31'(bus.ack), bus.timeout_err}, {31'h2, 1'b0});
    end
`endif
    bus.req = '0;
    step(); step();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req[i]) begin
          if ($urandom_range(2) == 0) bus.req[i] = 1'b1;
        end else if (m_ack[i]) begin
          if ($urandom_range(1) == 0) bus.req[i] = 1'b0;
        end else if ($urandom_range(15) == 0) begin
          bus.req[i] = 1'b0;
        end
      end
      bus.d_in = $urandom;
      if ($urandom_range(299) == 0) begin
        async_reset();
        step();
        reset = 1'b1;
      end else begin
        step();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
